// File: rtl/mips_fetch_stage.sv
// ============================================================================
// mips_fetch_stage : MIPS instruction fetch stage, PC register and IF/ID latch
// Revision 1.0
// ============================================================================
`default_nettype none

module mips_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        reset_i,
   output logic [31:0] imem_addr_o,
   input  logic [31:0] imem_data_i,
   input  logic        stall_i,
   input  logic        ex_redirect_i,
   input  logic [31:0] ex_target_i,
   input  logic        id_jump_i,
   output logic [31:0] id_instr_o,
   output logic [31:0] id_pcp4_o,
   output logic        id_valid_o,
   output logic [5:0]  opcode_o,
   output logic [5:0]  funccode_o,
   output logic        rt0_o,
   output logic        rt4_o,
   output logic [31:0] fetch_count_o,
   output logic [31:0] flush_count_o
);

   localparam logic [31:0] C_WORD_STEP = 32'd4;

   logic [31:0] pc_q,          pc_d;
   logic [31:0] id_instr_q,    id_instr_d;
   logic [31:0] id_pcp4_q,     id_pcp4_d;
   logic        id_valid_q,    id_valid_d;
   logic [31:0] fetch_count_q, fetch_count_d;
   logic [31:0] flush_count_q, flush_count_d;

   logic [31:0] w_pc_plus4;
   logic [31:0] w_jtarget;

   assign w_pc_plus4 = pc_q + C_WORD_STEP;
   assign w_jtarget  = {id_pcp4_q[31:28], id_instr_q[25:0], 2'b00};

   // A stalled jump needs no storage: IF/ID holds, so the decoder keeps
   // asserting id_jump_i until the stall releases.
   always_comb begin
      pc_d          = pc_q;
      id_instr_d    = id_instr_q;
      id_pcp4_d     = id_pcp4_q;
      id_valid_d    = id_valid_q;
      fetch_count_d = fetch_count_q;
      flush_count_d = flush_count_q;

      if (ex_redirect_i) begin
         pc_d          = {ex_target_i[31:2], 2'b00};
         id_instr_d    = NOP_WORD;
         id_pcp4_d     = 32'd0;
         id_valid_d    = 1'b0;
         flush_count_d = flush_count_q + 32'd1;
      end else if (stall_i) begin
         pc_d = pc_q;
      end else if (id_jump_i && id_valid_q) begin
         pc_d          = w_jtarget;
         id_instr_d    = NOP_WORD;
         id_pcp4_d     = 32'd0;
         id_valid_d    = 1'b0;
         flush_count_d = flush_count_q + 32'd1;
      end else begin
         pc_d          = w_pc_plus4;
         id_instr_d    = imem_data_i;
         id_pcp4_d     = w_pc_plus4;
         id_valid_d    = 1'b1;
         fetch_count_d = fetch_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         pc_q          <= RESET_PC;
         id_instr_q    <= NOP_WORD;
         id_pcp4_q     <= 32'd0;
         id_valid_q    <= 1'b0;
         fetch_count_q <= 32'd0;
         flush_count_q <= 32'd0;
      end else begin
         pc_q          <= pc_d;
         id_instr_q    <= id_instr_d;
         id_pcp4_q     <= id_pcp4_d;
         id_valid_q    <= id_valid_d;
         fetch_count_q <= fetch_count_d;
         flush_count_q <= flush_count_d;
      end
   end

   assign imem_addr_o   = pc_q;
   assign id_instr_o    = id_instr_q;
   assign id_pcp4_o     = id_pcp4_q;
   assign id_valid_o    = id_valid_q;
   assign opcode_o      = id_instr_q[31:26];
   assign funccode_o    = id_instr_q[5:0];
   assign rt0_o         = id_instr_q[16];
   assign rt4_o         = id_instr_q[20];
   assign fetch_count_o = fetch_count_q;
   assign flush_count_o = flush_count_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_fetch_stage.sv
// ============================================================================
// tb_mips_fetch_stage : directed scoreboard bench for mips_fetch_stage
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_mips_fetch_stage;

   logic        clk_i = 1'b0;
   logic        reset_i = 1'b1;
   logic [31:0] imem_addr_o;
   logic [31:0] imem_data_i;
   logic        stall_i = 1'b0;
   logic        ex_redirect_i = 1'b0;
   logic [31:0] ex_target_i = 32'd0;
   logic        id_jump_i = 1'b0;
   logic [31:0] id_instr_o;
   logic [31:0] id_pcp4_o;
   logic        id_valid_o;
   logic [5:0]  opcode_o;
   logic [5:0]  funccode_o;
   logic        rt0_o;
   logic        rt4_o;
   logic [31:0] fetch_count_o;
   logic [31:0] flush_count_o;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      string       tag;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] pcp4;
      logic        valid;
      logic [31:0] fetches;
      logic [31:0] flushes;
   } exp_t;

   exp_t sb_q[$];

   mips_fetch_stage #(
      .RESET_PC (32'h0000_0000),
      .NOP_WORD (32'h0000_0000)
   ) dut (
      .clk_i         (clk_i),
      .reset_i       (reset_i),
      .imem_addr_o   (imem_addr_o),
      .imem_data_i   (imem_data_i),
      .stall_i       (stall_i),
      .ex_redirect_i (ex_redirect_i),
      .ex_target_i   (ex_target_i),
      .id_jump_i     (id_jump_i),
      .id_instr_o    (id_instr_o),
      .id_pcp4_o     (id_pcp4_o),
      .id_valid_o    (id_valid_o),
      .opcode_o      (opcode_o),
      .funccode_o    (funccode_o),
      .rt0_o         (rt0_o),
      .rt4_o         (rt4_o),
      .fetch_count_o (fetch_count_o),
      .flush_count_o (flush_count_o)
   );

   always #5 clk_i = ~clk_i;

   // Instruction memory: a few fixed words, otherwise addiu-style filler tagged with the address.
   always_comb begin
      case (imem_addr_o)
         32'h0000_0000: imem_data_i = 32'h2008_0001;
         32'h0000_0004: imem_data_i = 32'h2009_0002;
         32'h0000_0008: imem_data_i = 32'h0109_5020;
         32'h0000_000C: imem_data_i = 32'h0800_0040;
         default:       imem_data_i = 32'h2400_0000 | {16'h0000, imem_addr_o[15:0]};
      endcase
   end

   task automatic chk(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s %s: got %h expected %h", tag, what, act, exp);
      end
   endtask

   // Monitor: every edge that has an outstanding expectation is checked just after it.
   always @(posedge clk_i) begin
      #1;
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         chk(e.tag, "pc",     imem_addr_o,   e.pc);
         chk(e.tag, "instr",  id_instr_o,    e.instr);
         chk(e.tag, "pcp4",   id_pcp4_o,     e.pcp4);
         chk(e.tag, "valid",  {31'd0, id_valid_o}, {31'd0, e.valid});
         chk(e.tag, "fetch",  fetch_count_o, e.fetches);
         chk(e.tag, "flush",  flush_count_o, e.flushes);
         chk(e.tag, "opcode", {26'd0, opcode_o},   {26'd0, e.instr[31:26]});
         chk(e.tag, "func",   {26'd0, funccode_o}, {26'd0, e.instr[5:0]});
         chk(e.tag, "rt0",    {31'd0, rt0_o},      {31'd0, e.instr[16]});
         chk(e.tag, "rt4",    {31'd0, rt4_o},      {31'd0, e.instr[20]});
      end
   end

   task automatic step(input string tag, input logic rst, input logic stl, input logic red,
                       input logic jmp, input logic [31:0] tgt,
                       input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] pcp4,
                       input logic valid, input logic [31:0] fetches, input logic [31:0] flushes);
      exp_t e;
      @(negedge clk_i);
      reset_i       = rst;
      stall_i       = stl;
      ex_redirect_i = red;
      id_jump_i     = jmp;
      ex_target_i   = tgt;
      e.tag = tag; e.pc = pc; e.instr = instr; e.pcp4 = pcp4;
      e.valid = valid; e.fetches = fetches; e.flushes = flushes;
      sb_q.push_back(e);
   endtask

   initial begin
      //    tag          rst  stl  red  jmp  target         pc             instr          pcp4          v  fetch flush
      step("reset",      1,   0,   0,   0,   32'h0,         32'h0000_0000, 32'h0000_0000, 32'h0,        0, 0, 0);
      step("free1",      0,   0,   0,   0,   32'h0,         32'h0000_0004, 32'h2008_0001, 32'h4,        1, 1, 0);
      step("free2",      0,   0,   0,   0,   32'h0,         32'h0000_0008, 32'h2009_0002, 32'h8,        1, 2, 0);
      step("stall1",     0,   1,   0,   0,   32'h0,         32'h0000_0008, 32'h2009_0002, 32'h8,        1, 2, 0);
      step("stall2",     0,   1,   0,   0,   32'h0,         32'h0000_0008, 32'h2009_0002, 32'h8,        1, 2, 0);
      step("resume",     0,   0,   0,   0,   32'h0,         32'h0000_000C, 32'h0109_5020, 32'hC,        1, 3, 0);
      step("fetch_j",    0,   0,   0,   0,   32'h0,         32'h0000_0010, 32'h0800_0040, 32'h10,       1, 4, 0);
      step("jump_stall", 0,   1,   0,   1,   32'h0,         32'h0000_0010, 32'h0800_0040, 32'h10,       1, 4, 0);
      step("jump",       0,   0,   0,   1,   32'h0,         32'h0000_0100, 32'h0000_0000, 32'h0,        0, 4, 1);
      step("jump_bubble",0,   0,   0,   1,   32'h0,         32'h0000_0104, 32'h2400_0100, 32'h104,      1, 5, 1);
      step("free3",      0,   0,   0,   0,   32'h0,         32'h0000_0108, 32'h2400_0104, 32'h108,      1, 6, 1);
      step("redir_all",  0,   1,   1,   1,   32'h0000_2003, 32'h0000_2000, 32'h0000_0000, 32'h0,        0, 6, 2);
      step("after_redir",0,   0,   0,   0,   32'h0,         32'h0000_2004, 32'h2400_2000, 32'h2004,     1, 7, 2);
      step("redir_top",  0,   0,   1,   0,   32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0,        0, 7, 3);
      step("wrap",       0,   0,   0,   0,   32'h0,         32'h0000_0000, 32'h2400_FFFC, 32'h0,        1, 8, 3);
      step("post_wrap",  0,   0,   0,   0,   32'h0,         32'h0000_0004, 32'h2008_0001, 32'h4,        1, 9, 3);
      step("rst_redir",  1,   0,   1,   1,   32'h0000_3000, 32'h0000_0000, 32'h0000_0000, 32'h0,        0, 0, 0);
      step("post_rst",   0,   0,   0,   0,   32'h0,         32'h0000_0004, 32'h2008_0001, 32'h4,        1, 1, 0);
      @(negedge clk_i);
      reset_i = 1'b0; stall_i = 1'b0; ex_redirect_i = 1'b0; id_jump_i = 1'b0;
      for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk_i);
      n_tests++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
